// File: rtl/tpu_control_unit.sv
// Instruction sequencer for an NxN systolic array: accepts 16-bit instructions and
// expands each multi-cycle opcode into registered strobe sequences for the datapath.
module tpu_control_unit #(
  parameter int N      = 2,
  parameter int ADDR_W = 13,
  parameter int CNT_W  = $clog2(2*N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              weight_load_en,
  output logic              input_load_en,
  output logic [CNT_W-1:0]  row_idx,
  output logic              compute_valid,
  output logic [CNT_W-1:0]  compute_step,
  output logic              acc_clear,
  output logic              drain,
  output logic              store_en,
  output logic              op_done,
  output logic              illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_I = 3'd2,
    S_FEED   = 3'd3,
    S_DRAIN  = 3'd4,
    S_STORE  = 3'd5
  } state_e;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOAD_ADDR = 3'b001;
  localparam logic [2:0] OP_LOAD_W    = 3'b010;
  localparam logic [2:0] OP_LOAD_I    = 3'b011;
  localparam logic [2:0] OP_COMPUTE   = 3'b100;
  localparam logic [2:0] OP_STORE     = 3'b101;

  localparam logic [CNT_W-1:0] LAST_ROW  = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2*N - 2);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                acc_mode_q, acc_mode_d;
  logic                illegal_q, illegal_d;

  logic                wl_q, wl_d;
  logic                il_q, il_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic                cv_q, cv_d;
  logic [CNT_W-1:0]    step_q, step_d;
  logic                clr_q, clr_d;
  logic                drain_q, drain_d;
  logic                st_q, st_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;

  logic [2:0]          opcode_s;
  logic [12:0]         operand_s;
  logic                accept_s;
  logic                row_phase_s;

  assign opcode_s    = instruction[15:13];
  assign operand_s   = instruction[12:0];
  assign accept_s    = instr_valid & (state_q == S_IDLE);
  assign instr_ready = (state_q == S_IDLE) & ~reset;

  // Next-state, counters and the registered strobe values for the coming cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    acc_mode_d = acc_mode_q;
    illegal_d  = illegal_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (accept_s) begin
          case (opcode_s)
            OP_NOP:       state_d = S_IDLE;
            OP_LOAD_ADDR: base_d  = operand_s[ADDR_W-1:0];
            OP_LOAD_W:    state_d = S_LOAD_W;
            OP_LOAD_I:    state_d = S_LOAD_I;
            OP_COMPUTE: begin
              state_d    = S_FEED;
              acc_mode_d = operand_s[0];
            end
            OP_STORE:     state_d = S_STORE;
            default:      illegal_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W, S_LOAD_I, S_STORE, S_DRAIN: begin
        if (cnt_q == LAST_ROW) begin
          state_d = S_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_FEED: begin
        if (cnt_q == LAST_STEP) begin
          state_d = S_DRAIN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    // Outputs are decoded from the next state so every strobe leaves a flop.
    row_phase_s = (state_d == S_LOAD_W) || (state_d == S_LOAD_I) || (state_d == S_STORE);
    wl_d        = (state_d == S_LOAD_W);
    il_d        = (state_d == S_LOAD_I);
    st_d        = (state_d == S_STORE);
    cv_d        = (state_d == S_FEED);
    drain_d     = (state_d == S_DRAIN);
    row_d       = row_phase_s ? cnt_d : {CNT_W{1'b0}};
    step_d      = cv_d ? cnt_d : {CNT_W{1'b0}};
    clr_d       = cv_d && (cnt_d == {CNT_W{1'b0}}) && !acc_mode_d;
    maddr_d     = row_phase_s ? (base_d + ADDR_W'(cnt_d)) : base_d;
  end

  // State and output registers; reset aborts any op without an op_done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      base_q     <= {ADDR_W{1'b0}};
      acc_mode_q <= 1'b0;
      illegal_q  <= 1'b0;
      wl_q       <= 1'b0;
      il_q       <= 1'b0;
      row_q      <= {CNT_W{1'b0}};
      cv_q       <= 1'b0;
      step_q     <= {CNT_W{1'b0}};
      clr_q      <= 1'b0;
      drain_q    <= 1'b0;
      st_q       <= 1'b0;
      done_q     <= 1'b0;
      maddr_q    <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      acc_mode_q <= acc_mode_d;
      illegal_q  <= illegal_d;
      wl_q       <= wl_d;
      il_q       <= il_d;
      row_q      <= row_d;
      cv_q       <= cv_d;
      step_q     <= step_d;
      clr_q      <= clr_d;
      drain_q    <= drain_d;
      st_q       <= st_d;
      done_q     <= done_d;
      maddr_q    <= maddr_d;
    end
  end

  assign base_addr      = base_q;
  assign mem_addr       = maddr_q;
  assign weight_load_en = wl_q;
  assign input_load_en  = il_q;
  assign row_idx        = row_q;
  assign compute_valid  = cv_q;
  assign compute_step   = step_q;
  assign acc_clear      = clr_q;
  assign drain          = drain_q;
  assign store_en       = st_q;
  assign op_done        = done_q;
  assign illegal_op     = illegal_q;

endmodule

// File: doc/tpu_control_unit.md
# tpu_control_unit

Instruction sequencer for the systolic-array datapath, parametrised in array size `N`. It accepts 16-bit instructions through a valid/ready handshake and latches the base address. It then expands each multi-cycle opcode into a cycle-exact strobe sequence for the weight loader, the input setup unit, the array, the accumulator and the unified buffer. This replaces hand-timed instruction streams: the controller inserts the feed and drain cycles itself, and it adds a STORE writeback path from the accumulator to the unified buffer.

## Interface
- `N`, 2: array dimension (N×N PEs), ≥2
- `ADDR_W`, 13: unified-buffer address width, ≤13
- `CNT_W`, $clog2(2*N): step counter width

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; forces all state and outputs to reset values immediately
- `instruction` in 16: [15:13] opcode, [12:0] operand
- `instr_valid` in 1: instruction presented
- `instr_ready` out 1: controller can accept; equals (state==IDLE) & ~reset
- `base_addr` out ADDR_W: latched base address, reset 0
- `mem_addr` out ADDR_W: unified-buffer address for current row = base_addr + row, modulo 2^ADDR_W; reset 0
- `weight_load_en` out 1: weight row transfer strobe, reset 0
- `input_load_en` out 1: activation row transfer strobe, reset 0
- `row_idx` out CNT_W: row index during LOAD_W / LOAD_I / STORE, else 0; reset 0
- `compute_valid` out 1: array feed cycle, reset 0
- `compute_step` out CNT_W: skew step 0..2N-2 during FEED, else 0; reset 0
- `acc_clear` out 1: clear accumulator, reset 0
- `drain` out 1: drain cycle (array flushing into accumulator), reset 0
- `store_en` out 1: accumulator row write to unified buffer, reset 0
- `op_done` out 1: one-cycle pulse when a multi-cycle op completes, reset 0
- `illegal_op` out 1: sticky flag, reset 0

## Operation
- Accept = instr_valid & instr_ready at a rising edge. Only one instruction is in flight.
- Opcodes:
  - 000 NOP: no effect.
  - 001 LOAD_ADDR: base_addr ← operand[ADDR_W-1:0]; single cycle; state stays IDLE.
  - 010 LOAD_WEIGHT: state LOAD_W for N cycles; weight_load_en=1, row_idx=0..N-1.
  - 011 LOAD_INPUT: state LOAD_I for N cycles; input_load_en=1, row_idx=0..N-1.
  - 100 COMPUTE: state FEED for 2N-1 cycles (compute_valid=1, compute_step=0..2N-2), then DRAIN for N cycles (drain=1). Operand bit 0 = accumulate mode. If bit0=0, acc_clear=1 on the first FEED cycle only. If bit0=1, acc_clear stays 0.
  - 101 STORE: state STORE for N cycles; store_en=1, row_idx=0..N-1.
  - 110, 111: consumed as NOP; illegal_op set and held until reset.
- In LOAD_W, LOAD_I and STORE, mem_addr = base_addr + row_idx, truncated to ADDR_W bits, so it wraps at 2^ADDR_W. In all other states mem_addr = base_addr.
- base_addr changes only on LOAD_ADDR. Multi-cycle ops use the value latched at accept.
- State machine:
  - IDLE → LOAD_W | LOAD_I | FEED | STORE on accept.
  - FEED → DRAIN when step = 2N-2.
  - LOAD_W, LOAD_I, DRAIN and STORE → IDLE after their last cycle.
- op_done pulses in the first IDLE cycle after any multi-cycle op.
- At most one of weight_load_en, input_load_en, compute_valid, drain, store_en is high in any cycle.

## Timing
- Accept at edge k → the op's strobes are high from cycle k+1. LOAD_ADDR's base_addr update is visible from cycle k+1.
- Latencies from accept to instr_ready=1 again:
  - LOAD_W, LOAD_I, STORE: N+1 cycles.
  - COMPUTE: 3N cycles.
  - LOAD_ADDR, NOP: 1 cycle; a new instruction can be accepted on every edge.
- instr_ready is low for the whole multi-cycle op. instruction and instr_valid are ignored while it is low.
- op_done and instr_ready=1 coincide. A new op may be accepted on that same edge.
- Reset asserted mid-operation aborts the op:
  - state → IDLE; all strobes, counters and base_addr → 0.
  - No op_done pulse.
  - illegal_op is cleared.
- Reset deasserted → instr_ready=1 combinationally. The first accept is possible on the next edge.

## Test plan
- Reset, then LOAD_ADDR 0x000F, then LOAD_WEIGHT (N=2) → weight_load_en high 2 cycles with mem_addr 15,16 and row_idx 0,1. op_done is then pulsed and instr_ready returns after 3 cycles.
- LOAD_ADDR 0x001E, LOAD_INPUT, COMPUTE operand 0 (N=2):
  - input_load_en on mem_addr 30,31.
  - compute_valid 3 cycles with compute_step 0,1,2; acc_clear only on step 0.
  - drain 2 cycles; instr_ready back 6 cycles after accept.
- COMPUTE operand 1 → identical sequence with acc_clear never asserted. LOAD_ADDR 0x1FFF then STORE → store_en on mem_addr 0x1FFF then 0x0000 (wrap).
- Back-to-back: LOAD_ADDR on 3 consecutive edges with values 5, 6, 7 → base_addr 5, 6, 7. Instructions presented while instr_ready=0 are ignored: base_addr is unchanged and no extra strobes appear.
- Opcode 111 → illegal_op=1 and stays set through subsequent legal ops, with no strobes. Reset clears it.
- Reset asserted on the 2nd FEED cycle with N=4 → all strobes 0 immediately and no op_done. After deassert, a new COMPUTE runs its full 7 FEED + 4 DRAIN cycles.
